// File: rtl/core_input_buf.sv
// core_input_buf: two-slot, 16-word block buffer between the block-input write bus and one SHA256 core
// Ports:
//   CLK, RST_N          clock and asynchronous active-low reset
//   wr_en/wr_addr/din   word write into slot wr_seq; wr_blk_op tags the slot
//   set_input_ready     level; its rising edge marks slot wr_seq complete
//   ready[1:0]          per-slot complete block held
//   rd_start/rd_seq     core requests a ready slot; rd_en advances one word
//   dout/dout_valid     registered read word and its fresh-this-cycle flag
//   rd_blk_op           block op of the slot being read
//   rd_done             pulse with the last word; the slot is already released
//   busy                a read is in progress
//   err                 sticky protocol-violation flag
module core_input_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int BLK_OP_MSB = 3
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  wr_en,
  input  logic [3:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [BLK_OP_MSB:0]   wr_blk_op,
  input  logic                  wr_seq,
  input  logic                  set_input_ready,
  output logic [1:0]            ready,
  input  logic                  rd_start,
  input  logic                  rd_seq,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic [BLK_OP_MSB:0]   rd_blk_op,
  output logic                  rd_done,
  output logic                  busy,
  output logic                  err
);
  typedef enum logic {IDLE, READ} state_t;
  state_t                state;
  logic [DATA_WIDTH-1:0] mem [2][16];
  logic [BLK_OP_MSB:0]   blk_op [2];
  logic                  sir_q, cur_seq, rise, last, bad;
  logic [3:0]            rd_addr;
  logic [1:0]            set_m, clr_m;
  assign busy  = state == READ;
  assign rise  = set_input_ready & ~sir_q;
  assign last  = busy & rd_en & (rd_addr == 4'hf);
  // set is OR-ed in after the clear, so a same-slot set wins
  assign set_m = rise ? 2'b01 << wr_seq : 2'b00;
  assign clr_m = last ? 2'b01 << cur_seq : 2'b00;
  assign bad   = (wr_en & (ready[wr_seq] | (busy & (wr_seq == cur_seq)))) | (rise & ready[wr_seq]);
  // storage is not reset; errant writes still land
  always_ff @(posedge CLK)
    if (wr_en) mem[wr_seq][wr_addr] <= din;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state      <= IDLE;
      cur_seq    <= 1'b0;
      rd_addr    <= 4'h0;
      dout       <= '0;
      dout_valid <= 1'b0;
      rd_done    <= 1'b0;
      rd_blk_op  <= '0;
      ready      <= 2'b00;
      err        <= 1'b0;
      sir_q      <= 1'b0;
      blk_op     <= '{default: '0};
    end else begin
      sir_q      <= set_input_ready;
      ready      <= (ready & ~clr_m) | set_m;
      err        <= err | bad;
      if (wr_en) blk_op[wr_seq] <= wr_blk_op;
      dout_valid <= busy & rd_en;
      rd_done    <= last;
      if (busy) begin
        if (rd_en) dout <= mem[cur_seq][rd_addr];
        rd_addr <= rd_en ? rd_addr + 4'h1 : rd_addr;
        state   <= last ? IDLE : READ;
      end else if (rd_start && ready[rd_seq]) begin
        cur_seq   <= rd_seq;
        rd_addr   <= 4'h0;
        rd_blk_op <= blk_op[rd_seq];
        state     <= READ;
      end
    end
endmodule

// File: tb/tb_core_input_buf.sv
// tb_core_input_buf: table vectors, directed sequences and random traffic against a slot/word-count model
module tb_core_input_buf;
  logic        CLK = 0, RST_N = 0;
  logic        wr_en = 0, wr_seq = 0, sir = 0, rd_start = 0, rd_seq = 0, rd_en = 0;
  logic [3:0]  wr_addr = 0, wr_blk_op = 0, rd_blk_op;
  logic [31:0] din = 0, dout;
  logic [1:0]  ready;
  logic        dout_valid, rd_done, busy, err;
  int checks = 0, errors = 0;

  core_input_buf #(.DATA_WIDTH(32), .BLK_OP_MSB(3)) dut (
    .CLK(CLK), .RST_N(RST_N), .wr_en(wr_en), .wr_addr(wr_addr), .din(din),
    .wr_blk_op(wr_blk_op), .wr_seq(wr_seq), .set_input_ready(sir), .ready(ready),
    .rd_start(rd_start), .rd_seq(rd_seq), .rd_en(rd_en), .dout(dout),
    .dout_valid(dout_valid), .rd_blk_op(rd_blk_op), .rd_done(rd_done),
    .busy(busy), .err(err));

  always #5 CLK = ~CLK;

  // reference model: block contents, slot flags, and the slot/word-count of the read in progress
  logic [31:0] mm [2][16];
  logic [3:0]  m_op [2];
  bit   [1:0]  m_ready;
  bit          m_err, m_reading, m_slot, m_sirq, e_valid, e_done;
  int          m_cnt;
  logic [31:0] e_dout;
  logic [3:0]  e_rdop;

  task automatic model_reset();
    m_ready = 0; m_err = 0; m_reading = 0; m_slot = 0; m_sirq = 0; m_cnt = 0;
    e_valid = 0; e_done = 0; e_dout = 0; e_rdop = 0; m_op[0] = 0; m_op[1] = 0;
  endtask

  task automatic model_update();
    bit rise = sir && !m_sirq;
    if (wr_en && (m_ready[wr_seq] || (m_reading && wr_seq == m_slot))) m_err = 1;
    if (rise && m_ready[wr_seq]) m_err = 1;
    e_valid = 0; e_done = 0;
    if (m_reading) begin
      if (rd_en) begin
        e_valid = 1;
        e_dout = mm[m_slot][m_cnt];
        m_cnt++;
        if (m_cnt == 16) begin m_ready[m_slot] = 0; m_reading = 0; e_done = 1; end
      end
    end else if (rd_start && m_ready[rd_seq]) begin
      m_reading = 1; m_slot = rd_seq; m_cnt = 0; e_rdop = m_op[rd_seq];
    end
    if (rise) m_ready[wr_seq] = 1;
    if (wr_en) begin mm[wr_seq][wr_addr] = din; m_op[wr_seq] = wr_blk_op; end
    m_sirq = sir;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".ready"}, 32'(ready), 32'(m_ready));
    chk({tag, ".busy"}, 32'(busy), 32'(m_reading));
    chk({tag, ".dout"}, dout, e_dout);
    chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(e_valid));
    chk({tag, ".rd_done"}, 32'(rd_done), 32'(e_done));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
    chk({tag, ".rd_blk_op"}, 32'(rd_blk_op), 32'(e_rdop));
  endtask

  task automatic tick(string tag = "m");
    model_update();
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic idle_in();
    wr_en = 0; sir = 0; rd_start = 0; rd_en = 0;
  endtask

  task automatic do_reset();
    idle_in();
    RST_N = 0;
    #2;
    model_reset();
    check_all("rst");
    @(negedge CLK);
    RST_N = 1;
  endtask

  task automatic fill(input bit s, input logic [31:0] base, input logic [3:0] op);
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wr_seq = s; wr_addr = 4'(i); din = base + 32'(i); wr_blk_op = op; sir = (i == 15);
      tick("fill");
    end
    idle_in();
    tick("fill");
  endtask

  task automatic read_blk(input bit s, input logic [31:0] base, input logic [3:0] op, input bit gap);
    rd_start = 1; rd_seq = s;
    tick("start");
    rd_start = 0;
    chk("start.busy", 32'(busy), 1);
    chk("start.op", 32'(rd_blk_op), 32'(op));
    for (int i = 0; i < 16; i++) begin
      rd_en = 1;
      tick("rd");
      chk("rd.dout", dout, base + 32'(i));
      chk("rd.valid", 32'(dout_valid), 1);
      chk("rd.done", 32'(rd_done), 32'(i == 15));
      rd_en = 0;
      if (gap && i < 15) begin
        tick("gap");
        chk("gap.valid", 32'(dout_valid), 0);
        chk("gap.hold", dout, base + 32'(i));
      end
    end
  endtask

  typedef struct {
    bit w, ws, s, rs, rq, re;
    bit [1:0] x_ready;
    bit x_busy, x_err;
  } vec_t;
  vec_t vec [9];

  initial begin
    vec[0] = '{0, 0, 1, 0, 0, 0, 2'b01, 0, 0};
    vec[1] = '{0, 0, 0, 0, 0, 0, 2'b01, 0, 0};
    vec[2] = '{0, 0, 0, 1, 1, 0, 2'b01, 0, 0};
    vec[3] = '{0, 0, 0, 0, 0, 1, 2'b01, 0, 0};
    vec[4] = '{0, 1, 1, 0, 0, 0, 2'b11, 0, 0};
    vec[5] = '{0, 0, 1, 0, 0, 0, 2'b11, 0, 0};
    vec[6] = '{0, 0, 0, 1, 1, 0, 2'b11, 1, 0};
    vec[7] = '{0, 0, 0, 1, 0, 0, 2'b11, 1, 0};
    vec[8] = '{1, 0, 0, 0, 0, 0, 2'b11, 1, 1};
    model_reset();
    repeat (2) @(negedge CLK);
    check_all("por");
    RST_N = 1;
    for (int i = 0; i < 32; i++) begin
      wr_en = 1; wr_seq = i[4]; wr_addr = i[3:0]; din = 32'hA000 + 32'(i); wr_blk_op = 0;
      tick("pre");
    end
    idle_in();
    tick("pre");

    do_reset();
    for (int i = 0; i < 9; i++) begin
      wr_en = vec[i].w; wr_seq = vec[i].ws; wr_addr = 0; din = 32'hBAD0; sir = vec[i].s;
      rd_start = vec[i].rs; rd_seq = vec[i].rq; rd_en = vec[i].re;
      tick("vec");
      chk($sformatf("vec%0d.ready", i), 32'(ready), 32'(vec[i].x_ready));
      chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vec[i].x_busy));
      chk($sformatf("vec%0d.err", i), 32'(err), 32'(vec[i].x_err));
    end

    do_reset();
    fill(0, 32'h1000, 2);
    chk("basic.ready", 32'(ready), 2'b01);
    read_blk(0, 32'h1000, 2, 0);
    chk("basic.ready_after", 32'(ready), 0);

    fill(0, 32'h2000, 5);
    fill(1, 32'h3000, 6);
    chk("inter.ready11", 32'(ready), 2'b11);
    read_blk(1, 32'h3000, 6, 0);
    chk("inter.ready01", 32'(ready), 2'b01);
    read_blk(0, 32'h2000, 5, 0);
    chk("inter.ready00", 32'(ready), 0);

    fill(0, 32'h4000, 7);
    rd_start = 1; rd_seq = 0;
    tick("fdr");
    rd_start = 0;
    for (int i = 0; i < 16; i++) begin
      rd_en = 1; wr_en = 1; wr_seq = 1; wr_addr = 4'(i); din = 32'h5000 + 32'(i); wr_blk_op = 9; sir = (i == 15);
      tick("fdr");
      chk("fdr.dout", dout, 32'h4000 + 32'(i));
    end
    idle_in();
    tick("fdr");
    chk("fdr.err", 32'(err), 0);
    chk("fdr.ready", 32'(ready), 2'b10);

    read_blk(1, 32'h5000, 9, 1);
    chk("gap.ready", 32'(ready), 0);

    fill(0, 32'h6000, 1);
    fill(1, 32'h7000, 4);
    rd_start = 1; rd_seq = 0;
    tick("b2b");
    rd_start = 0; rd_en = 1;
    repeat (16) tick("b2b");
    rd_en = 0;
    chk("b2b.done", 32'(rd_done), 1);
    rd_start = 1; rd_seq = 1; wr_en = 1; wr_seq = 0; wr_addr = 0; din = 32'h6100;
    tick("b2b");
    idle_in();
    chk("b2b.busy", 32'(busy), 1);
    chk("b2b.err", 32'(err), 0);
    rd_en = 1;
    repeat (16) tick("b2b");
    idle_in();

    fill(0, 32'h8000, 3);
    wr_en = 1; wr_seq = 0; wr_addr = 3; din = 32'hDEAD;
    tick("viol");
    idle_in();
    chk("viol.err", 32'(err), 1);
    rd_start = 1; rd_seq = 1;
    tick("viol");
    rd_start = 0;
    chk("viol.busy", 32'(busy), 0);
    chk("viol.err_held", 32'(err), 1);

    do_reset();
    fill(0, 32'h9000, 5);
    rd_start = 1; rd_seq = 0;
    tick("mid");
    rd_start = 0; rd_en = 1;
    repeat (5) tick("mid");
    chk("mid.dout5", dout, 32'h9004);
    @(negedge CLK);
    RST_N = 0;
    #1;
    chk("mid.ready", 32'(ready), 0);
    chk("mid.busy", 32'(busy), 0);
    chk("mid.dout", dout, 0);
    chk("mid.valid", 32'(dout_valid), 0);
    chk("mid.op", 32'(rd_blk_op), 0);
    chk("mid.done", 32'(rd_done), 0);
    chk("mid.err", 32'(err), 0);
    model_reset();
    idle_in();
    @(negedge CLK);
    RST_N = 1;
    rd_start = 1; rd_seq = 0;
    tick("mid");
    rd_start = 0;
    chk("mid.ignored", 32'(busy), 0);

    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) do_reset();
      wr_en = ($urandom_range(0, 99) < 25);
      wr_seq = 1'($urandom);
      wr_addr = 4'($urandom);
      din = $urandom;
      wr_blk_op = 4'($urandom);
      if ($urandom_range(0, 5) == 0) sir = ~sir;
      rd_start = ($urandom_range(0, 99) < 15);
      rd_seq = 1'($urandom);
      rd_en = ($urandom_range(0, 99) < 70);
      tick("rnd");
    end
    idle_in();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/core_input_buf.md
# core_input_buf

Per-core receive end of the block-input write interface. It accepts 16-word block writes (word enable, 4-bit word address, block op, thread sequence bit, block-complete strobe) into one of two thread slots. It holds each completed block until the SHA256 core reads it out word by word, then releases the slot for the next fill. One instance sits in front of each core; each instance's `wr_en` is driven by its bit of the per-core write-enable vector.

## Interface
- `DATA_WIDTH`, 32, width of one block word
- `BLK_OP_MSB`, `` `BLK_OP_MSB ``, MSB of the block-op field
- `CLK`  in  1  single clock; all logic on rising edge
- `RST_N`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  write `din` at (`wr_seq`, `wr_addr`)
- `wr_addr`  in  4  word index 0..15
- `din`  in  DATA_WIDTH  write data
- `wr_blk_op`  in  BLK_OP_MSB+1  block op of the block being written
- `wr_seq`  in  1  thread slot being written
- `set_input_ready`  in  1  level; its rising edge marks the `wr_seq` slot complete
- `ready`  out  2  per-slot "complete block held"
- `rd_start`  in  1  core requests slot `rd_seq`
- `rd_seq`  in  1  slot to read
- `rd_en`  in  1  advance one word
- `dout`  out  DATA_WIDTH  registered read word
- `dout_valid`  out  1  `dout` holds a fresh word this cycle
- `rd_blk_op`  out  BLK_OP_MSB+1  block op of the slot being read
- `rd_done`  out  1  one-cycle pulse; last word delivered and slot released
- `busy`  out  1  a read is in progress
- `err`  out  1  sticky protocol-violation flag

## Operation
- Storage: 2 slots × 16 words, distributed RAM; per-slot `blk_op` register and `ready` bit.
- Write side:
  - Every `wr_en` writes `din` to mem[`wr_seq`][`wr_addr`] and loads `blk_op[wr_seq]` with `wr_blk_op`.
  - `set_input_ready` is registered. The cycle with `set_input_ready` = 1 and previous value 0 sets `ready[wr_seq]`.
  - `set_input_ready` held high over idle cycles produces no further sets.
- Read FSM, states IDLE and READ:
  - IDLE: `rd_start` & `ready[rd_seq]` latches `cur_seq` = `rd_seq`, clears `rd_addr`, and enters READ.
  - In IDLE, `rd_start` on a non-ready slot is ignored.
  - READ: each `rd_en` reads mem[`cur_seq`][`rd_addr`] into `dout` with `dout_valid` = 1 on the next cycle, then increments `rd_addr`.
  - READ: `rd_en` with `rd_addr` = 15 clears `ready[cur_seq]`, pulses `rd_done` one cycle later (with the last `dout_valid`), and returns to IDLE.
  - `rd_start` in READ is ignored.
- `rd_blk_op` = `blk_op[cur_seq]`, registered when READ is entered.
- `busy` = (state == READ).
- `err` is set, and stays set until reset, by any of:
  - `wr_en` to a slot with `ready` = 1;
  - `wr_en` to `cur_seq` while `busy`;
  - a rising edge of `set_input_ready` on a slot already ready.
- Errant writes still update memory. An errant rising edge leaves `ready` = 1.
- Simultaneous events:
  - A set of `ready[s]` and a clear of `ready[s]` in the same cycle: the set wins.
  - A set and a clear on different slots in the same cycle are both applied.

## Timing
- Reset values: `ready` = 0, `dout` = 0, `dout_valid` = 0, `rd_blk_op` = 0, `rd_done` = 0, `busy` = 0, `err` = 0, FSM in IDLE, `rd_addr` = 0, `set_input_ready` register = 0. Memory contents are not reset.
- Reset asserted mid-read returns the FSM to IDLE immediately and drops all held blocks.
- Write latency:
  - A word written at cycle t is readable from t+1.
  - `ready` rises one cycle after the `set_input_ready` edge is sampled.
- Read latency:
  - `rd_start` at t gives `busy` = 1 and valid `rd_blk_op` at t+1.
  - The first `rd_en` may be issued at t+1.
  - `rd_en` at t gives `dout`/`dout_valid` at t+1.
- Throughput: one word per cycle; a full block reads in 16 `rd_en` cycles.
- `rd_en` gaps are allowed; `dout_valid` = 0 in gap cycles and `dout` holds its last value.
- `rd_en` in IDLE is ignored.
- Back-to-back: the next `rd_start` is accepted the cycle `rd_done` is high.
- A slot released by `rd_done` can take a new write the same cycle without setting `err`.

## Test plan
- Basic block:
  - Stimulus: write words 0x1000+i at addr i, seq 0, blk_op 2, with `set_input_ready` rising on the addr-15 cycle, then `rd_start` seq 0 and 16 consecutive `rd_en`.
  - Required: `ready` = 2'b01; `dout` sequence 0x1000..0x100F; `rd_blk_op` = 2; `rd_done` coincides with 0x100F; `ready` = 0 afterwards.
- Interleaved threads:
  - Stimulus: fill seq 0 then seq 1, read seq 1 first, then seq 0.
  - Required: each `dout` sequence matches its slot; `ready` goes 11 → 01 → 00.
- Fill during read:
  - Stimulus: while reading seq 0, write the full block of seq 1.
  - Required: no `err`; `ready[1]` set; seq 0 data uncorrupted.
- Gapped read:
  - Stimulus: `rd_en` asserted every other cycle.
  - Required: 16 valid words, `dout_valid` only on the cycle after each `rd_en`, `rd_done` on the 16th.
- Violations:
  - Stimulus: write to ready slot 0; separately, `rd_start` on an empty slot.
  - Required: the first sets `err` = 1; the second leaves `busy` = 0 and `err` unchanged.
- Reset mid-read:
  - Stimulus: deassert `RST_N` after 5 words.
  - Required: all outputs at reset values asynchronously; a subsequent `rd_start` is ignored until a new block completes.
